// File: rtl/axi_mem_slave.sv
// rtl/axi_mem_slave.sv - AXI4 responder backed by a DEPTH x 64-bit word array
// Independent read/write FSMs, FIXED/INCR bursts, per-beat OKAY/SLVERR/DECERR.
module axi_mem_slave #(
  parameter int          DEPTH     = 65536,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          RD_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ar_valid,
  output logic        ar_ready,
  input  logic [3:0]  ar_id,
  input  logic [31:0] ar_addr,
  input  logic [7:0]  ar_len,
  input  logic [2:0]  ar_size,
  input  logic [1:0]  ar_brust,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [3:0]  r_id,
  output logic [63:0] r_data,
  output logic [1:0]  r_resp,
  output logic        r_last,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [3:0]  aw_id,
  input  logic [31:0] aw_addr,
  input  logic [7:0]  aw_len,
  input  logic [2:0]  aw_size,
  input  logic [1:0]  aw_brust,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [63:0] w_data,
  input  logic [7:0]  w_strb,
  input  logic        w_last,
  output logic        b_valid,
  input  logic        b_ready,
  output logic [3:0]  b_id,
  output logic [1:0]  b_resp
);
  localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] ARR_BYTES = 33'(DEPTH) * 33'd8;
  localparam logic [15:0] WAIT_INIT = (RD_LAT > 0) ? 16'(RD_LAT - 1) : 16'd0;

  function automatic logic [1:0] f_resp(input logic [31:0] addr, input logic [2:0] size,
                                        input logic [1:0] burst);
    if ({1'b0, addr - BASE_ADDR} >= ARR_BYTES) return 2'b11;
    if (burst[1] || (size > 3'd3)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] f_next(input logic [31:0] addr, input logic [2:0] size,
                                         input logic [1:0] burst);
    return (burst == 2'b00) ? addr : addr + (32'd1 << size);
  endfunction

  function automatic logic [IW-1:0] f_idx(input logic [31:0] addr);
    return IW'((addr - BASE_ADDR) >> 3);
  endfunction

  function automatic logic [1:0] f_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [63:0] r_mem [DEPTH];

  // ---------------- read channel ----------------
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rstate_t;
  rstate_t     r_rstate;
  logic [15:0] r_rwait;
  logic [31:0] r_raddr;
  logic [7:0]  r_rlen, r_rbeat;
  logic [2:0]  r_rsize;
  logic [1:0]  r_rburst, r_rresp;
  logic [3:0]  r_rid;
  logic        r_ar_ready, r_rvalid, r_rlast;
  logic [63:0] r_rdata;

  logic [31:0] w_rnext, w_ld_addr;
  logic [2:0]  w_ld_size;
  logic [1:0]  w_ld_burst, w_ld_resp;
  logic [63:0] w_ld_data;

  // Beat address being loaded: from the AR bus (zero latency), the latched start, or the next beat.
  always_comb begin
    w_rnext    = f_next(r_raddr, r_rsize, r_rburst);
    w_ld_addr  = r_raddr;
    w_ld_size  = r_rsize;
    w_ld_burst = r_rburst;
    if (r_rstate == R_IDLE) begin
      w_ld_addr  = ar_addr;
      w_ld_size  = ar_size;
      w_ld_burst = ar_brust;
    end else if (r_rstate == R_BURST) begin
      w_ld_addr = w_rnext;
    end
    w_ld_resp = f_resp(w_ld_addr, w_ld_size, w_ld_burst);
    w_ld_data = (w_ld_resp == 2'b00) ? r_mem[f_idx(w_ld_addr)] : 64'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate   <= R_IDLE;
      r_rwait    <= '0;
      r_raddr    <= '0;
      r_rlen     <= '0;
      r_rbeat    <= '0;
      r_rsize    <= '0;
      r_rburst   <= '0;
      r_rid      <= '0;
      r_ar_ready <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (r_ar_ready && ar_valid) begin
            r_ar_ready <= 1'b0;
            r_rid      <= ar_id;
            r_raddr    <= ar_addr;
            r_rlen     <= ar_len;
            r_rsize    <= ar_size;
            r_rburst   <= ar_brust;
            r_rbeat    <= '0;
            if (RD_LAT == 0) begin
              r_rvalid <= 1'b1;
              r_rdata  <= w_ld_data;
              r_rresp  <= w_ld_resp;
              r_rlast  <= (ar_len == 8'd0);
              r_rstate <= R_BURST;
            end else begin
              r_rwait  <= WAIT_INIT;
              r_rstate <= R_WAIT;
            end
          end else begin
            r_ar_ready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_rwait == 16'd0) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_ld_data;
            r_rresp  <= w_ld_resp;
            r_rlast  <= (r_rlen == 8'd0);
            r_rstate <= R_BURST;
          end else begin
            r_rwait <= r_rwait - 16'd1;
          end
        end
        R_BURST: begin
          if (r_ready) begin
            if (r_rlast) begin
              r_rvalid   <= 1'b0;
              r_rlast    <= 1'b0;
              r_rdata    <= '0;
              r_rresp    <= '0;
              r_ar_ready <= 1'b1;
              r_rstate   <= R_IDLE;
            end else begin
              r_raddr <= w_rnext;
              r_rbeat <= r_rbeat + 8'd1;
              r_rdata <= w_ld_data;
              r_rresp <= w_ld_resp;
              r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign ar_ready = r_ar_ready;
  assign r_valid  = r_rvalid;
  assign r_id     = r_rid;
  assign r_data   = r_rdata;
  assign r_resp   = r_rresp;
  assign r_last   = r_rlast;

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  wstate_t     r_wstate;
  logic [31:0] r_waddr;
  logic [7:0]  r_wlen, r_wbeat;
  logic [2:0]  r_wsize;
  logic [1:0]  r_wburst, r_werr, r_b_resp;
  logic [3:0]  r_wid;
  logic        r_aw_ready, r_w_ready, r_b_valid;

  logic [1:0]    w_wresp_beat, w_wacc;
  logic          w_wlast_exp, w_whs, w_mem_we;
  logic [IW-1:0] w_widx;

  always_comb begin
    w_whs        = r_w_ready && w_valid;
    w_wresp_beat = f_resp(r_waddr, r_wsize, r_wburst);
    w_wlast_exp  = (r_wbeat == r_wlen);
    w_wacc       = f_max(r_werr, f_max(w_wresp_beat, (w_last != w_wlast_exp) ? 2'b10 : 2'b00));
    w_mem_we     = w_whs && (w_wresp_beat == 2'b00);
    w_widx       = f_idx(r_waddr);
  end

  // Array has no reset; an async reset drops the FSM out of W_DATA so no later write fires.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (w_strb[i]) r_mem[w_widx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate   <= W_IDLE;
      r_waddr    <= '0;
      r_wlen     <= '0;
      r_wbeat    <= '0;
      r_wsize    <= '0;
      r_wburst   <= '0;
      r_werr     <= '0;
      r_wid      <= '0;
      r_aw_ready <= 1'b0;
      r_w_ready  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_b_resp   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (r_aw_ready && aw_valid) begin
            r_aw_ready <= 1'b0;
            r_wid      <= aw_id;
            r_waddr    <= aw_addr;
            r_wlen     <= aw_len;
            r_wsize    <= aw_size;
            r_wburst   <= aw_brust;
            r_wbeat    <= '0;
            r_werr     <= '0;
            r_w_ready  <= 1'b1;
            r_wstate   <= W_DATA;
          end else begin
            r_aw_ready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_whs) begin
            if (w_wlast_exp) begin
              r_w_ready <= 1'b0;
              r_b_valid <= 1'b1;
              r_b_resp  <= w_wacc;
              r_wstate  <= W_RESP;
            end else begin
              r_werr  <= w_wacc;
              r_waddr <= f_next(r_waddr, r_wsize, r_wburst);
              r_wbeat <= r_wbeat + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (b_ready) begin
            r_b_valid  <= 1'b0;
            r_b_resp   <= '0;
            r_aw_ready <= 1'b1;
            r_wstate   <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign aw_ready = r_aw_ready;
  assign w_ready  = r_w_ready;
  assign b_valid  = r_b_valid;
  assign b_id     = r_wid;
  assign b_resp   = r_b_resp;
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb/tb_axi_mem_slave.sv - directed self-checking bench for axi_mem_slave
module tb_axi_mem_slave;
  logic        clk, rst_n;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_brust;
  logic        r_valid, r_ready;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        aw_valid, aw_ready;
  logic [3:0]  aw_id;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_brust;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        b_valid, b_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;

  axi_mem_slave dut (
    .clk(clk), .rst_n(rst_n),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_brust(ar_brust),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_size(aw_size), .aw_brust(aw_brust),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [63:0] wd [8];
  logic [7:0]  ws [8];
  logic [63:0] rdd [8];
  logic [1:0]  rdr [8];
  logic        rdl [8];
  logic [3:0]  rdid;
  int          rlat;

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic [7:0] lastmask,
                           output logic [3:0] bid, output logic [1:0] bresp);
    int t;
    aw_addr = addr; aw_len = len; aw_size = size; aw_brust = burst; aw_id = id; aw_valid = 1'b1;
    t = 0;
    while (!aw_ready && t < 100) begin @(negedge clk); t++; end
    check("aw_timeout", 64'(t < 100), 64'd1);
    @(negedge clk);
    aw_valid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      w_data = wd[b]; w_strb = ws[b]; w_last = lastmask[b]; w_valid = 1'b1;
      t = 0;
      while (!w_ready && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
    end
    w_valid = 1'b0; w_last = 1'b0;
    b_ready = 1'b1;
    t = 0;
    while (!b_valid && t < 100) begin @(negedge clk); t++; end
    check("b_timeout", 64'(t < 100), 64'd1);
    bid = b_id; bresp = b_resp;
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input bit bp);
    int nb, t;
    logic tog, stall, rr, sl;
    logic [63:0] sd;
    logic [1:0] sr;
    ar_addr = addr; ar_len = len; ar_size = size; ar_brust = burst; ar_id = id; ar_valid = 1'b1;
    t = 0;
    while (!ar_ready && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    ar_valid = 1'b0;
    rlat = 1;
    while (!r_valid && rlat < 100) begin @(negedge clk); rlat++; end
    nb = 0; t = 0; tog = 1'b0; stall = 1'b0; sd = '0; sl = 1'b0; sr = '0;
    while (nb <= int'(len) && t < 200) begin
      if (stall) begin
        check("stall_valid", 64'(r_valid), 64'd1);
        check("stall_data", r_data, sd);
        check("stall_last", 64'(r_last), 64'(sl));
        check("stall_resp", 64'(r_resp), 64'(sr));
      end
      if (r_valid) begin
        rr = bp ? tog : 1'b1;
        tog = ~tog;
        r_ready = rr;
        if (rr) begin
          rdd[nb] = r_data; rdr[nb] = r_resp; rdl[nb] = r_last; rdid = r_id;
          nb++; stall = 1'b0;
        end else begin
          sd = r_data; sl = r_last; sr = r_resp; stall = 1'b1;
        end
      end else begin
        r_ready = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    r_ready = 1'b0;
    check("rd_timeout", 64'(t < 200), 64'd1);
    check("rd_end_valid", 64'(r_valid), 64'd0);
    check("rd_end_arready", 64'(ar_ready), 64'd1);
  endtask

  logic [3:0] bid, bid2;
  logic [1:0] bresp, bresp2;
  int t, wn, rn;
  logic hs_w, hs_r;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_brust = 0; r_ready = 0;
    aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_brust = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    for (int i = 0; i < 8; i++) begin wd[i] = '0; ws[i] = 8'hFF; end
    repeat (3) @(negedge clk);
    check("rst_data", r_data, 64'd0);
    check("rst_ctl", 64'({ar_ready, r_valid, r_id, r_resp, r_last, aw_ready, w_ready,
                          b_valid, b_id, b_resp}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_arready", 64'(ar_ready), 64'd1);
    check("rel_awready", 64'(aw_ready), 64'd1);

    // single beat write then readback
    wd[0] = 64'h1122334455667788;
    axi_write(32'h8000_0010, 8'd0, 3'd3, 2'b01, 4'h5, 8'h01, bid, bresp);
    check("t1_bresp", 64'(bresp), 64'd0);
    check("t1_bid", 64'(bid), 64'h5);
    axi_read(32'h8000_0010, 8'd0, 3'd3, 2'b01, 4'h9, 1'b0);
    check("t1_latency", 64'(rlat), 64'd3);
    check("t1_data", rdd[0], 64'h1122334455667788);
    check("t1_last", 64'(rdl[0]), 64'd1);
    check("t1_resp", 64'(rdr[0]), 64'd0);
    check("t1_rid", 64'(rdid), 64'h9);

    // INCR burst fill, then backpressured readback
    for (int i = 0; i < 4; i++) wd[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
    axi_write(32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'h2, 8'h08, bid, bresp);
    check("t2_bresp", 64'(bresp), 64'd0);
    axi_read(32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'h3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_data%0d", i), rdd[i], 64'hC0DE_0000_0000_0000 + 64'(i));
      check($sformatf("t2_last%0d", i), 64'(rdl[i]), 64'(i == 3));
    end

    // FIXED burst stays on word 1; narrow INCR returns full aligned words
    axi_read(32'h8000_0008, 8'd1, 3'd3, 2'b00, 4'h1, 1'b0);
    check("fix_b0", rdd[0], 64'hC0DE_0000_0000_0001);
    check("fix_b1", rdd[1], 64'hC0DE_0000_0000_0001);
    axi_read(32'h8000_0000, 8'd3, 3'd2, 2'b01, 4'h1, 1'b0);
    check("nar_b0", rdd[0], 64'hC0DE_0000_0000_0000);
    check("nar_b1", rdd[1], 64'hC0DE_0000_0000_0000);
    check("nar_b2", rdd[2], 64'hC0DE_0000_0000_0001);
    check("nar_b3", rdd[3], 64'hC0DE_0000_0000_0001);

    // byte strobes
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    axi_write(32'h8000_0100, 8'd0, 3'd3, 2'b01, 4'h0, 8'h01, bid, bresp);
    wd[0] = 64'd0; ws[0] = 8'h0F;
    axi_write(32'h8000_0100, 8'd0, 3'd3, 2'b01, 4'h0, 8'h01, bid, bresp);
    ws[0] = 8'hFF;
    axi_read(32'h8000_0100, 8'd0, 3'd3, 2'b01, 4'h0, 1'b0);
    check("strb_data", rdd[0], 64'hFFFF_FFFF_0000_0000);

    // decode and slave errors
    axi_read(32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 4'h0, 1'b0);
    check("dec_lo_resp", 64'(rdr[0]), 64'd3);
    check("dec_lo_data", rdd[0], 64'd0);
    axi_read(32'h8008_0000, 8'd0, 3'd3, 2'b01, 4'h0, 1'b0);
    check("dec_hi_resp", 64'(rdr[0]), 64'd3);
    axi_read(32'h8007_FFF8, 8'd0, 3'd3, 2'b01, 4'h0, 1'b0);
    check("top_word_resp", 64'(rdr[0]), 64'd0);
    axi_read(32'h8000_0000, 8'd0, 3'd3, 2'b10, 4'h0, 1'b0);
    check("rd_wrap_resp", 64'(rdr[0]), 64'd2);
    check("rd_wrap_data", rdd[0], 64'd0);
    wd[0] = 64'h1234;
    axi_write(32'h8000_0100, 8'd0, 3'd3, 2'b10, 4'h7, 8'h01, bid, bresp);
    check("wr_wrap_bresp", 64'(bresp), 64'd2);
    axi_read(32'h8000_0100, 8'd0, 3'd3, 2'b01, 4'h0, 1'b0);
    check("wr_wrap_nowrite", rdd[0], 64'hFFFF_FFFF_0000_0000);
    axi_write(32'h8000_0200, 8'd1, 3'd3, 2'b01, 4'h6, 8'h01, bid, bresp);
    check("early_last_bresp", 64'(bresp), 64'd2);
    axi_write(32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 4'h6, 8'h01, bid, bresp);
    check("wr_dec_bresp", 64'(bresp), 64'd3);
    axi_write(32'h8000_0300, 8'd0, 3'd4, 2'b01, 4'h6, 8'h01, bid, bresp);
    check("wr_size_bresp", 64'(bresp), 64'd2);

    // concurrent read and write bursts
    for (int i = 0; i < 8; i++) wd[i] = 64'hD000_0000_0000_0000 + 64'(i);
    axi_write(32'h8000_1000, 8'd7, 3'd3, 2'b01, 4'h1, 8'h80, bid, bresp);
    for (int i = 0; i < 8; i++) wd[i] = 64'hE000_0000_0000_0000 + 64'(i);
    fork
      axi_write(32'h8000_2000, 8'd7, 3'd3, 2'b01, 4'hA, 8'h80, bid2, bresp2);
      axi_read(32'h8000_1000, 8'd7, 3'd3, 2'b01, 4'hB, 1'b0);
    join
    check("cc_bresp", 64'(bresp2), 64'd0);
    check("cc_bid", 64'(bid2), 64'hA);
    check("cc_rid", 64'(rdid), 64'hB);
    for (int i = 0; i < 8; i++)
      check($sformatf("cc_rd%0d", i), rdd[i], 64'hD000_0000_0000_0000 + 64'(i));
    axi_read(32'h8000_2000, 8'd7, 3'd3, 2'b01, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++)
      check($sformatf("cc_wr%0d", i), rdd[i], 64'hE000_0000_0000_0000 + 64'(i));

    // concurrent bursts aborted by reset at read beat 3
    for (int i = 0; i < 8; i++) wd[i] = 64'h5555_0000_0000_0000 + 64'(i);
    axi_write(32'h8000_3000, 8'd7, 3'd3, 2'b01, 4'h0, 8'h80, bid, bresp);
    for (int i = 0; i < 8; i++) wd[i] = 64'hAB00_0000_0000_0000 + 64'(i);
    ar_addr = 32'h8000_1000; ar_len = 8'd7; ar_size = 3'd3; ar_brust = 2'b01; ar_valid = 1'b1;
    aw_addr = 32'h8000_3000; aw_len = 8'd7; aw_size = 3'd3; aw_brust = 2'b01; aw_valid = 1'b1;
    @(negedge clk);
    ar_valid = 1'b0; aw_valid = 1'b0;
    w_valid = 1'b1; w_data = wd[0]; w_strb = 8'hFF; w_last = 1'b0; r_ready = 1'b1;
    wn = 0; rn = 0; t = 0;
    while (!(r_valid && rn == 3) && t < 100) begin
      hs_w = w_valid && w_ready;
      hs_r = r_valid && r_ready;
      @(negedge clk);
      t++;
      if (hs_w) begin wn++; w_data = wd[wn]; end
      if (hs_r) rn++;
    end
    check("rst_seq_timeout", 64'(t < 100), 64'd1);
    check("rst_beat3_data", r_data, 64'hD000_0000_0000_0003);
    check("rst_wbeats", 64'(wn), 64'd5);
    rst_n = 1'b0;
    #1;
    check("midrst_data", r_data, 64'd0);
    check("midrst_ctl", 64'({ar_ready, r_valid, r_id, r_resp, r_last, aw_ready, w_ready,
                             b_valid, b_id, b_resp}), 64'd0);
    w_valid = 1'b0; r_ready = 1'b0; w_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrel_arready", 64'(ar_ready), 64'd1);
    check("midrel_awready", 64'(aw_ready), 64'd1);
    check("midrel_rvalid", 64'(r_valid), 64'd0);
    check("midrel_bvalid", 64'(b_valid), 64'd0);
    axi_read(32'h8000_3000, 8'd7, 3'd3, 2'b01, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++)
      check($sformatf("midrst_mem%0d", i), rdd[i],
            (i < 5) ? 64'hAB00_0000_0000_0000 + 64'(i) : 64'h5555_0000_0000_0000 + 64'(i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
